mem_responder: RTL and testbench
================================

# mem_responder

Word-organised unified instruction/data memory that answers the multicycle controller's fetch, load and store requests over a req/ready handshake with a configurable number of wait states. It sits between the datapath's address mux and the IR/MDR registers, so processor-side stall behaviour can be exercised against realistic memory latency. Each request is latched, delayed, then completed with a single-cycle `ready` pulse carrying read data or an error flag.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words; power of two.
- `WAIT_CYCLES`, 2: wait states inserted before completion; 0 to 15.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  1  request strobe; sampled only while idle.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `addr`  in  32  byte address; `addr[1:0]` must be 0.
- `wdata`  in  32  store data; sampled with `req`.
- `wstrb`  in  4  byte-lane write enables, bit i covers `wdata[8i+7:8i]`; sampled with `req`.
- `busy`  out  1  high from the cycle after acceptance through the `ready` cycle.
- `ready`  out  1  single-cycle completion pulse.
- `rdata`  out  32  read data; valid while `ready` is high, held until the next completion.
- `err`  out  1  qualifies `ready`: access was misaligned or out of range.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On `req` = 1, latch `we`, `addr`, `wdata` and `wstrb`.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to WAIT, or directly to RESP if `WAIT_CYCLES` = 0.
- WAIT: decrement the counter each cycle; at count 1 go to RESP.
- RESP:
  - `ready` = 1.
  - Write: commit the enabled byte lanes to `mem[addr[log2(DEPTH)+1:2]]`. `rdata` is unchanged.
  - Read: `rdata` = the addressed word.
  - Always return to IDLE next cycle. Back-to-back requests need `req` high in the IDLE cycle that follows.
- `req` while in WAIT or RESP is ignored; it is neither queued nor errored.
- Misaligned access (`addr[1:0]` ≠ 0): `err` = 1 with `ready`, no write, `rdata` = 0.
- `wstrb` = 0 on a write: legal no-op, completes normally with `err` = 0.
- Memory array contents are not reset.

## Timing
- Reset values: state IDLE, counter 0, `busy` 0, `ready` 0, `err` 0, `rdata` 0.
- Latency: `req` is sampled at edge N, and `ready` is high during cycle N + `WAIT_CYCLES` + 1.
- Throughput: one access per `WAIT_CYCLES` + 2 cycles.
- A write becomes visible to a read accepted in the IDLE cycle right after the write's RESP.
- Reset asserted mid-access (WAIT or RESP) takes effect immediately:
  - The pending write is discarded.
  - No `ready` pulse is produced.
  - `rdata` is cleared.
- `err` and `ready` are registered outputs, with no combinational path from `req`.

## Configuration
- `MEM_BOUNDS_CHECK_EN` defined: a word index ≥ `DEPTH` (any set bit in `addr[31:log2(DEPTH)+2]`) completes with `err` = 1, no write, and `rdata` = 0, using the same latency as a normal access.
- Not defined: upper address bits are ignored and the address wraps modulo `DEPTH` words; `err` reports misalignment only.

## Test plan
- Write then read, `WAIT_CYCLES` = 2:
  - Write `0xDEADBEEF` to `0x10` with `wstrb` = `4'hF`: `ready` in 3rd cycle after acceptance, `err` = 0.
  - Then read `0x10`: `rdata` = `0xDEADBEEF`.
- Byte lanes: over `0xDEADBEEF`, write `0x000000AA` with `wstrb` = `4'b0001`, then read → `0xDEADBEAA`.
- Misaligned: read at `0x13` → `ready` with `err` = 1, `rdata` = 0; memory unchanged.
- Reset mid-WAIT: pull `rst` low during WAIT of a write of `0x12345678` to `0x20`, release, then read `0x20` → previous contents; no stray `ready`.
- Request while busy: pulse `req` during WAIT → exactly one `ready`; with `WAIT_CYCLES` = 0, back-to-back reads complete every 2 cycles.
- Out of range, `DEPTH` = 1024, address `0x1000`:
  - With `MEM_BOUNDS_CHECK_EN`: `err` = 1.
  - Without: access aliases word 0, and a write there is read back at `0x0`.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/completion bus between the multicycle controller (master) and mem_responder (slave).
// req/we/addr/wdata/wstrb are sampled only while the responder is idle; ready is a one-cycle completion pulse.
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        busy;
  logic        ready;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  busy, ready, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output busy, ready, rdata, err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-organised unified memory answering req/ready accesses after WAIT_CYCLES wait states.
// Optional macro MEM_BOUNDS_CHECK_EN: word indices >= DEPTH complete with err instead of wrapping.
module mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus,
  output logic [1:0]     dbg_state
);
  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          we_q, we_d;
  logic          bad_q, bad_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] req_idx, resp_idx;
  logic          req_bad, resp_bad, resp_we, enter_resp;

`ifndef MEM_BOUNDS_CHECK_EN
  logic unused_hi_addr;
  assign unused_hi_addr = ^bus.addr[31:AW+2];
`endif

  always_comb begin
    req_idx = bus.addr[AW+1:2];
    req_bad = (bus.addr[1:0] != 2'b00);
`ifdef MEM_BOUNDS_CHECK_EN
    req_bad = req_bad | (bus.addr[31:AW+2] != '0);
`endif

    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    bad_d      = bad_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    enter_resp = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          bad_d   = req_bad;
          idx_d   = req_idx;
          wdata_d = bus.wdata;
          wstrb_d = bus.wstrb;
          cnt_d   = WAIT_INIT;
          if (WAIT_INIT == 4'd0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d    = S_RESP;
          cnt_d      = 4'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // With zero wait states the response is formed straight from the bus in the accepting cycle.
    resp_we  = (state_q == S_IDLE) ? bus.we  : we_q;
    resp_bad = (state_q == S_IDLE) ? req_bad : bad_q;
    resp_idx = (state_q == S_IDLE) ? req_idx : idx_q;

    if (enter_resp) begin
      ready_d = 1'b1;
      err_d   = resp_bad;
      if (resp_bad) begin
        rdata_d = 32'd0;
      end else if (!resp_we) begin
        rdata_d = mem[resp_idx];
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      we_q    <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      bad_q   <= bad_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  // Commit happens on the edge that leaves RESP, so a reset during RESP discards the write.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && we_q && !bad_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.busy  = busy_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states, one with none, shared clock and reset.
module tb_mem_responder;
  logic clk;
  logic rst_n;
  logic [1:0] dbg_a, dbg_b;

  mem_responder_if ba ();
  mem_responder_if bb ();

  mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst_n), .bus(ba), .dbg_state(dbg_a)
  );
  mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst_n), .bus(bb), .dbg_state(dbg_b)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_fail   = 0;
  int ready_cnt [2] = '{0, 0};
  logic [32:0] exp_q[$];
  logic [31:0] model [2][1024];
  logic [31:0] last_rd [2] = '{32'd0, 32'd0};

  always @(negedge clk) begin
    if (ba.ready === 1'b1) ready_cnt[0]++;
    if (bb.ready === 1'b1) ready_cnt[1]++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    if (sel == 0) begin
      ba.req = r; ba.we = w; ba.addr = a; ba.wdata = d; ba.wstrb = s;
    end else begin
      bb.req = r; bb.we = w; bb.addr = a; bb.wdata = d; bb.wstrb = s;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? ba.ready : bb.ready;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? ba.busy : bb.busy;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 0) ? ba.err : bb.err;
  endfunction
  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 0) ? ba.rdata : bb.rdata;
  endfunction

  function automatic logic is_bad(input logic [31:0] a);
    logic bad;
    bad = (a[1:0] != 2'b00);
`ifdef MEM_BOUNDS_CHECK_EN
    bad = bad || (a >= 32'h0000_1000);
`endif
    return bad;
  endfunction

  // Reference model: {err, rdata} expected for one access; updates the model memory for good writes.
  task automatic predict(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [32:0] e);
    logic [9:0] wi;
    wi = a[11:2];
    if (is_bad(a)) begin
      e = {1'b1, 32'd0};
    end else if (w) begin
      e = {1'b0, last_rd[sel]};
      for (int i = 0; i < 4; i++) begin
        if (s[i]) model[sel][wi][8*i +: 8] = d[8*i +: 8];
      end
    end else begin
      e = {1'b0, model[sel][wi]};
    end
    last_rd[sel] = e[31:0];
  endtask

  task automatic access(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit poke, input string tag);
    logic [32:0] e;
    int cycles;
    int lat;
    lat = (sel == 0) ? 3 : 1;
    @(negedge clk);
    drive(sel, 1'b1, w, a, d, s);
    predict(sel, w, a, d, s, e);
    exp_q.push_back(e);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (poke && cycles == 1) drive(sel, 1'b1, 1'b1, 32'h40, 32'hBAD0_BAD0, 4'hF);
      else drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      if (cycles == 1) check({tag, " busy"}, 32'(get_busy(sel)), 32'd1);
    end while (get_ready(sel) !== 1'b1 && cycles < 20);
    check({tag, " ready seen"}, 32'(get_ready(sel)), 32'd1);
    e = exp_q.pop_front();
    if (get_ready(sel) === 1'b1) begin
      check({tag, " latency"}, 32'(cycles), 32'(lat));
      check({tag, " err"}, 32'(get_err(sel)), 32'(e[32]));
      check({tag, " rdata"}, get_rdata(sel), e[31:0]);
      @(negedge clk);
      check({tag, " ready pulse"}, 32'(get_ready(sel)), 32'd0);
      check({tag, " busy clear"}, 32'(get_busy(sel)), 32'd0);
    end
  endtask

  initial begin
    logic [32:0] e;
    logic [31:0] sa [4];
    logic        sw [4];
    logic [31:0] sd [4];
    int          cnt0;

    // reset
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset state_a", 32'(dbg_a), 32'd0);
    check("reset busy_a",  32'(ba.busy), 32'd0);
    check("reset ready_a", 32'(ba.ready), 32'd0);
    check("reset err_a",   32'(ba.err), 32'd0);
    check("reset rdata_a", ba.rdata, 32'd0);
    check("reset state_b", 32'(dbg_b), 32'd0);
    check("reset ready_b", 32'(bb.ready), 32'd0);
    check("reset rdata_b", bb.rdata, 32'd0);

    // write/read and byte lanes
    access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, "wr10");
    access(0, 1'b0, 32'h10, 32'd0, 4'h0, 1'b0, "rd10");
    access(0, 1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 1'b0, "wr10 lane0");
    access(0, 1'b0, 32'h10, 32'd0, 4'h0, 1'b0, "rd10 lane0");

    // misaligned, then memory unchanged
    access(0, 1'b0, 32'h13, 32'd0, 4'h0, 1'b0, "rd13 misaligned");
    access(0, 1'b1, 32'h12, 32'hFFFF_FFFF, 4'hF, 1'b0, "wr12 misaligned");
    access(0, 1'b0, 32'h10, 32'd0, 4'h0, 1'b0, "rd10 after misaligned");

    // wstrb = 0 is a no-op write
    access(0, 1'b1, 32'h10, 32'h1234_5678, 4'h0, 1'b0, "wr10 nostrb");
    access(0, 1'b0, 32'h10, 32'd0, 4'h0, 1'b0, "rd10 after nostrb");

    // reset mid-WAIT discards the write
    access(0, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 1'b0, "wr20");
    cnt0 = ready_cnt[0];
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 4'hF);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    check("abort in wait", 32'(dbg_a), 32'd1);
    check("abort rdata before", ba.rdata, last_rd[0]);
    rst_n = 1'b0;
    #1;
    check("abort state", 32'(dbg_a), 32'd0);
    check("abort busy", 32'(ba.busy), 32'd0);
    check("abort rdata", ba.rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    repeat (4) @(negedge clk);
    check("abort no ready", 32'(ready_cnt[0] - cnt0), 32'd0);
    access(0, 1'b0, 32'h20, 32'd0, 4'h0, 1'b0, "rd20 after abort");

    // request during WAIT is ignored
    access(0, 1'b1, 32'h40, 32'h55AA_55AA, 4'hF, 1'b0, "wr40");
    cnt0 = ready_cnt[0];
    access(0, 1'b0, 32'h10, 32'd0, 4'h0, 1'b1, "rd10 poked");
    repeat (3) @(negedge clk);
    check("poke single ready", 32'(ready_cnt[0] - cnt0), 32'd1);
    access(0, 1'b0, 32'h40, 32'd0, 4'h0, 1'b0, "rd40 after poke");

    // out of range: error with bounds checking, alias of word 0 without
    access(0, 1'b1, 32'h0, 32'h1111_1111, 4'hF, 1'b0, "wr0");
    access(0, 1'b1, 32'h1000, 32'h0BAD_CAFE, 4'hF, 1'b0, "wr1000");
    access(0, 1'b0, 32'h0, 32'd0, 4'h0, 1'b0, "rd0 after wr1000");
    access(0, 1'b0, 32'h1000, 32'd0, 4'h0, 1'b0, "rd1000");

    // zero wait states: back-to-back stream, one completion every two cycles
    access(1, 1'b1, 32'h4, $urandom, 4'hF, 1'b0, "b wr4");
    access(1, 1'b1, 32'h8, $urandom, 4'hF, 1'b0, "b wr8");
    sw[0] = 1'b1; sa[0] = 32'h30; sd[0] = $urandom;
    sw[1] = 1'b0; sa[1] = 32'h30; sd[1] = 32'd0;
    sw[2] = 1'b0; sa[2] = 32'h4;  sd[2] = 32'd0;
    sw[3] = 1'b0; sa[3] = 32'h8;  sd[3] = 32'd0;
    cnt0 = ready_cnt[1];
    @(negedge clk);
    drive(1, 1'b1, sw[0], sa[0], sd[0], 4'hF);
    predict(1, sw[0], sa[0], sd[0], 4'hF, e);
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("stream%0d ready", i), 32'(bb.ready), 32'd1);
      e = exp_q.pop_front();
      check($sformatf("stream%0d err", i), 32'(bb.err), 32'(e[32]));
      check($sformatf("stream%0d rdata", i), bb.rdata, e[31:0]);
      if (i < 3) begin
        drive(1, 1'b1, sw[i+1], sa[i+1], sd[i+1], 4'hF);
        predict(1, sw[i+1], sa[i+1], sd[i+1], 4'hF, e);
        exp_q.push_back(e);
      end else begin
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      end
      @(negedge clk);
      check($sformatf("stream%0d idle gap", i), 32'(bb.ready), 32'd0);
    end
    repeat (2) @(negedge clk);
    check("stream ready count", 32'(ready_cnt[1] - cnt0), 32'd4);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    // report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
